ins_queue: RTL and testbench
============================

Name: ins_queue

Overview:
- Parametrised successor to the single instruction register: a DEPTH-entry instruction prefetch queue between memory data bus and control unit decode.
- Accepts fetched instruction words on load, presents opcode and address fields of the oldest entry, retires it on a decode-side advance.
- Adds queue status and flush so fetch can run ahead of execution; branch/jump flushes.

Parameters:
- DATA_W, 16, instruction word width.
- OP_W, 3, opcode field width, taken from the MSBs of the word.
- ADR_W, 6, address field width, taken from the LSBs of the word; OP_W+ADR_W <= DATA_W.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- ce  input  1  global clock enable; push, pop and flush act only when ce=1.
- data  input  DATA_W  instruction word from memory.
- load_RI  input  1  push request.
- next_RI  input  1  pop request (decode consumed head).
- flush  input  1  discard all entries.
- code_op  output  OP_W  head[DATA_W-1 -: OP_W]; 0 when empty.
- ADR_RI  output  ADR_W  head[ADR_W-1:0]; 0 when empty.
- instr  output  DATA_W  full head word; 0 when empty.
- valid  output  1  queue non-empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous, any time incl. mid-operation): rd/wr pointers=0, count=0, valid=0, full=0, code_op/ADR_RI/instr=0. Storage contents need not be cleared; outputs are masked by valid.
- All state updates on posedge clk, only when ce=1; ce=0 holds all state regardless of other inputs.
- Effective push = ce & load_RI & (!full | pop_eff); effective pop = ce & next_RI & valid.
- Push: data written at wr pointer, wr pointer +1 modulo DEPTH (wraps naturally), count +1.
- Pop: rd pointer +1 modulo DEPTH, count -1.
- Push and pop same cycle: both occur, count unchanged. Legal when full (slot freed) and when count=1.
- Push when empty with next_RI=1: pop ignored (nothing to pop), push occurs; count becomes 1.
- Push when full without pop: word dropped, state unchanged.
- Pop when empty: ignored.
- flush (with ce=1) has priority: pointers and count to 0; simultaneous push is dropped, pop is ignored.
- Latency: word pushed at edge N is visible on code_op/ADR_RI/instr after edge N (same cycle as valid=1). Head outputs combinationally decoded from storage at rd pointer, gated by valid.
- FIFO order strictly preserved; DEPTH=1 not supported.

Optional Feature:
- Macro INSQ_OVF_STATS_EN.
- Defined: extra outputs ovf (1 bit, sticky) and ovf_cnt (8 bits, saturating at 255). Each dropped push (ce & load_RI & full & !pop, flush=0) sets ovf and increments ovf_cnt. Both clear only on reset; flush does not clear them.
- Not defined: ports and logic absent; drops are silent.

Test Plan:
- Reset then push 16'hA00A, 16'h4005 (DEPTH=4) -> after first edge valid=1, code_op=3'b101, ADR_RI=6'h0A; count=2 after second push.
- Fill 4 entries 16'h2001..16'h2004, push 16'hFFFF -> full=1, count=4, word dropped; 4 pops return 01,02,03,04 in order, then valid=0, code_op=0. With INSQ_OVF_STATS_EN: ovf=1, ovf_cnt=1.
- Full queue, load_RI=1 and next_RI=1 with data=16'h6007 -> count stays 4; 16'h6007 emerges after the 3 older entries; pointers wrap correctly across 10 cycles of continuous push+pop.
- ce=0 with load_RI=1, next_RI=1, flush=1 for 3 cycles -> count, head, valid unchanged.
- 3 entries queued, flush=1 with load_RI=1 -> next cycle count=0, valid=0; pushed word not present.
- Assert rst=0 asynchronously mid-cycle with count=2 -> outputs zero immediately without waiting for a clock edge; after release, first push of 16'hC03F gives code_op=3'b110, ADR_RI=6'h3F.

Source files
------------

// File: rtl/ins_queue_if.sv
// rtl/ins_queue_if.sv - fetch/decode bundle for the instruction prefetch queue
// Optional INSQ_OVF_STATS_EN adds the overflow statistics signals.
interface ins_queue_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3,
  parameter int ADR_W  = 6,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ce;
  logic [DATA_W-1:0] data;
  logic              load_RI;
  logic              next_RI;
  logic              flush;
  logic [OP_W-1:0]   code_op;
  logic [ADR_W-1:0]  ADR_RI;
  logic [DATA_W-1:0] instr;
  logic              valid;
  logic              full;
  logic [CNT_W-1:0]  count;
`ifdef INSQ_OVF_STATS_EN
  logic              ovf;
  logic [7:0]        ovf_cnt;
`endif

  modport master (
    output ce, data, load_RI, next_RI, flush,
`ifdef INSQ_OVF_STATS_EN
    input  ovf, ovf_cnt,
`endif
    input  code_op, ADR_RI, instr, valid, full, count
  );

  modport slave (
    input  ce, data, load_RI, next_RI, flush,
`ifdef INSQ_OVF_STATS_EN
    output ovf, ovf_cnt,
`endif
    output code_op, ADR_RI, instr, valid, full, count
  );
endinterface

// File: rtl/ins_queue.sv
// rtl/ins_queue.sv - DEPTH-entry instruction prefetch queue between fetch and decode
// Optional INSQ_OVF_STATS_EN enables sticky overflow flag and saturating drop counter.
module ins_queue #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3,
  parameter int ADR_W  = 6,
  parameter int DEPTH  = 4
) (
  input  logic  clk,
  input  logic  rst,
  ins_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              valid_w;
  logic              full_w;
  logic              pop_eff;
  logic              push_eff;
  logic [DATA_W-1:0] head;

  assign valid_w  = (count_q != '0);
  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign pop_eff  = bus.ce & bus.next_RI & valid_w;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push_eff = bus.ce & bus.load_RI & (~full_w | pop_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.ce) begin
      if (bus.flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_eff && !pop_eff)      count_q <= count_q + CNT_W'(1);
        else if (pop_eff && !push_eff) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; every read is masked by valid.
  always_ff @(posedge clk) begin
    if (push_eff && !bus.flush) mem[wr_ptr] <= bus.data;
  end

  assign head        = valid_w ? mem[rd_ptr] : '0;
  assign bus.instr   = head;
  assign bus.code_op = head[DATA_W-1 -: OP_W];
  assign bus.ADR_RI  = head[ADR_W-1:0];
  assign bus.valid   = valid_w;
  assign bus.full    = full_w;
  assign bus.count   = count_q;

`ifdef INSQ_OVF_STATS_EN
  logic       ovf_q;
  logic [7:0] ovf_cnt_q;
  logic       drop;

  assign drop = bus.ce & bus.load_RI & full_w & ~pop_eff & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign bus.ovf     = ovf_q;
  assign bus.ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_ins_queue.sv
// tb/tb_ins_queue.sv - directed self-checking bench for ins_queue
module tb_ins_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] exp_q[$];

  ins_queue_if #(.DATA_W(16), .OP_W(3), .ADR_W(6), .DEPTH(4)) bus ();

  ins_queue #(.DATA_W(16), .OP_W(3), .ADR_W(6), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load_RI = 1'b0;
    bus.next_RI = 1'b0;
    bus.flush   = 1'b0;
    bus.ce      = 1'b1;
  endtask

  task automatic push(input logic [15:0] w);
    bus.load_RI = 1'b1;
    bus.data    = w;
    step();
    bus.load_RI = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [15:0] w, input int cnt);
    check({tag, "_instr"}, 32'(bus.instr), 32'(w));
    check({tag, "_count"}, 32'(bus.count), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.data = '0;
    idle();
    step();
    step();
    check("rst_count", 32'(bus.count), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_code_op", 32'(bus.code_op), 0);
    check("rst_adr", 32'(bus.ADR_RI), 0);
    rst = 1'b1;
    step();

    push(16'hA00A);
    check("p1_valid", 32'(bus.valid), 1);
    check("p1_code_op", 32'(bus.code_op), 32'h5);
    check("p1_adr", 32'(bus.ADR_RI), 32'h0A);
    push(16'h4005);
    check_head("p2", 16'hA00A, 2);

    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush0_count", 32'(bus.count), 0);

    for (int i = 1; i <= 4; i++) push(16'h2000 + 16'(i));
    check("fill_full", 32'(bus.full), 1);
    push(16'hFFFF);
    check_head("drop", 16'h2001, 4);
    check("drop_full", 32'(bus.full), 1);
`ifdef INSQ_OVF_STATS_EN
    check("ovf", 32'(bus.ovf), 1);
    check("ovf_cnt", 32'(bus.ovf_cnt), 1);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("pop_head", 32'(bus.instr), 32'h2000 + 32'(i));
      bus.next_RI = 1'b1;
      step();
      bus.next_RI = 1'b0;
    end
    check("empty_valid", 32'(bus.valid), 0);
    check("empty_code_op", 32'(bus.code_op), 0);
    check("empty_instr", 32'(bus.instr), 0);
    bus.next_RI = 1'b1;
    step();
    bus.next_RI = 1'b0;
    check("pop_empty_count", 32'(bus.count), 0);

    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      push(16'h2000 + 16'(i));
      exp_q.push_back(16'h2000 + 16'(i));
    end
    for (int i = 0; i < 10; i++) begin
      bus.load_RI = 1'b1;
      bus.next_RI = 1'b1;
      bus.data    = 16'h6007 + 16'(i);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(16'h6007 + 16'(i));
      check_head("wrap", exp_q[0], 4);
    end
    idle();
    check("wrap_final_head", 32'(bus.instr), 32'h600D);

    bus.ce      = 1'b0;
    bus.load_RI = 1'b1;
    bus.next_RI = 1'b1;
    bus.flush   = 1'b1;
    bus.data    = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      check_head("ce_hold", 16'h600D, 4);
      check("ce_hold_valid", 32'(bus.valid), 1);
    end
    idle();

    bus.next_RI = 1'b1;
    step();
    bus.next_RI = 1'b0;
    check_head("pre_flush", 16'h600E, 3);
    bus.flush   = 1'b1;
    bus.load_RI = 1'b1;
    bus.data    = 16'h1234;
    step();
    idle();
    check_head("flush_push", 16'h0000, 0);
    check("flush_valid", 32'(bus.valid), 0);
    step();
    check("flush_after", 32'(bus.count), 0);
`ifdef INSQ_OVF_STATS_EN
    check("ovf_kept", 32'(bus.ovf), 1);
    check("ovf_cnt_kept", 32'(bus.ovf_cnt), 1);
`endif

    push(16'h1111);
    push(16'h2222);
    check_head("pre_arst", 16'h1111, 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_valid", 32'(bus.valid), 0);
    check("arst_instr", 32'(bus.instr), 0);
`ifdef INSQ_OVF_STATS_EN
    check("arst_ovf", 32'(bus.ovf), 0);
`endif
    step();
    #3;
    rst = 1'b1;
    step();
    bus.load_RI = 1'b1;
    bus.next_RI = 1'b1;
    bus.data    = 16'hC03F;
    step();
    idle();
    check("post_code_op", 32'(bus.code_op), 32'h6);
    check("post_adr", 32'(bus.ADR_RI), 32'h3F);
    check("post_count", 32'(bus.count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
